flag_branch_unit: RTL and testbench
===================================

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 set_flags  input  1  EX-stage instruction is valid and flag-setting (ADDS/SUBS) this cycle.
REQ-005 alu_zero, alu_neg, alu_ovf, alu_carry  input  1 each  ALU flags of the EX-stage result this cycle.
REQ-006 reg_zero  input  1  64-bit zero detect of the CBZ/CBNZ test register; 1 = register is all zeros.
REQ-007 br_valid  input  1  a branch instruction is presented this cycle.
REQ-008 br_type  input  2  00 = B (unconditional), 01 = CBZ, 10 = CBNZ, 11 = B.cond.
REQ-009 br_cond  input  4  ARM condition code, used only when br_type = 11.
REQ-010 flags_q  output  4  architectural {N,Z,C,V} flag register.
REQ-011 br_done  output  1  registered; 1 for exactly one cycle after each accepted branch.
REQ-012 br_taken  output  1  registered outcome; valid only when br_done = 1, else 0.
REQ-013 taken_cnt  output  16  saturating count of taken branches.

Function
REQ-014 When set_flags = 1, flags_q SHALL load {alu_neg, alu_zero, alu_carry, alu_ovf} at the next edge; otherwise flags_q SHALL hold.
REQ-015 B.cond SHALL evaluate "effective flags": the ALU flags when set_flags = 1 in the same cycle (forwarding), else flags_q.
REQ-016 Condition decode SHALL be: 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 1.
REQ-017 CBZ SHALL be taken iff reg_zero = 1; CBNZ iff reg_zero = 0; B SHALL always be taken; CBZ/CBNZ SHALL NOT read or modify flags.
REQ-018 Latency: br_valid at edge k SHALL produce br_done = 1 and br_taken = outcome during cycle k+1; with br_valid = 0, br_done = 0 and br_taken = 0.
REQ-019 Back-to-back branches (br_valid high on consecutive cycles) SHALL each resolve independently: one br_done pulse per cycle, no stall, no drop.
REQ-020 A B.cond issued in the cycle after a flag-setting instruction SHALL see the updated flags_q, i.e. no hazard bubble is needed.
REQ-021 taken_cnt SHALL increment by 1 at the edge where a taken branch is registered, and SHALL saturate at 16'hFFFF.
REQ-022 Inputs other than br_valid and set_flags SHALL be don't-care while their qualifier is 0; X on these inputs SHALL NOT propagate to the outputs.
REQ-023 Internal state SHALL be limited to flags_q, br_done, br_taken and taken_cnt; no FSM beyond these registers.

Reset
REQ-024 While reset = 1 at an edge: flags_q = 4'b0000, br_done = 0, br_taken = 0, taken_cnt = 0, regardless of set_flags or br_valid.
REQ-025 A branch presented in the same cycle as reset SHALL be discarded: no br_done pulse after reset deasserts.
REQ-026 The first edge with reset = 0 SHALL behave as normal operation; no warm-up cycles.

Verification
REQ-027 Reset, then set_flags = 1 with alu_zero = 1 and other flags 0; next cycle B.cond EQ -> flags_q = 4'b0100; br_done = 1, br_taken = 1 one cycle later; taken_cnt = 1.
REQ-028 Same cycle: set_flags = 1 with alu_neg = 1, alu_ovf = 0, flags_q = 0; B.cond LT -> br_taken = 1 (forwarded), not 0 (stale).
REQ-029 CBZ with reg_zero = 0, then CBNZ with reg_zero = 0 on consecutive cycles -> br_done pulses on two consecutive cycles with br_taken = 0 then 1; flags_q unchanged.
REQ-030 Sweep all 16 br_cond values against all 16 flag combinations -> br_taken matches the REQ-016 table in every case.
REQ-031 Preload taken_cnt to 16'hFFFE via 65534 B instructions, then issue 3 more -> taken_cnt = 16'hFFFF and stays there.
REQ-032 Assert reset in the same cycle as br_valid = 1 and set_flags = 1 -> no br_done pulse afterwards; flags_q = 0 and taken_cnt = 0.

Source files
------------

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural NZCV flag register plus a single-cycle
// branch resolver for B, CBZ, CBNZ and B.cond, with a saturating count of
// taken branches. B.cond sees ALU flags forwarded from the same cycle.
module flag_branch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_flags,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    input  logic        alu_carry,
    input  logic        reg_zero,
    input  logic        br_valid,
    input  logic [1:0]  br_type,
    input  logic [3:0]  br_cond,
    output logic [3:0]  flags_q,
    output logic        br_done,
    output logic        br_taken,
    output logic [15:0] taken_cnt
);

    localparam logic [1:0] BR_B    = 2'b00;
    localparam logic [1:0] BR_CBZ  = 2'b01;
    localparam logic [1:0] BR_CBNZ = 2'b10;
    localparam logic [1:0] BR_COND = 2'b11;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // ARM condition-code evaluation against {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic r;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = c;
            4'd3:    r = !c;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = c & !z;
            4'd9:    r = !c | z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z & (n == v);
            4'd13:   r = z | (n != v);
            default: r = 1'b1;  // AL and NV both always pass
        endcase
        return r;
    endfunction

    logic [3:0]  alu_flags;
    logic [3:0]  eff_flags;
    logic [3:0]  flags_d;
    logic        taken_d;
    logic [15:0] cnt_d;

    // Effective flags: forward this cycle's ALU flags when they are being written.
    always_comb begin
        alu_flags = {alu_neg, alu_zero, alu_carry, alu_ovf};
        eff_flags = set_flags ? alu_flags : flags_q;
        flags_d   = set_flags ? alu_flags : flags_q;
    end

    // Branch outcome; only qualified inputs are looked at so idle-cycle X stays out.
    always_comb begin
        taken_d = 1'b0;
        if (br_valid) begin
            case (br_type)
                BR_B:    taken_d = 1'b1;
                BR_CBZ:  taken_d = reg_zero;
                BR_CBNZ: taken_d = !reg_zero;
                BR_COND: taken_d = cond_pass(br_cond, eff_flags);
                default: taken_d = 1'b0;
            endcase
        end
    end

    // Saturating taken-branch counter next value.
    always_comb begin
        cnt_d = taken_cnt;
        if (taken_d && (taken_cnt != CNT_MAX)) begin
            cnt_d = taken_cnt + 16'd1;
        end
    end

    // State update: flags, one-cycle branch result pulse, taken counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= 4'b0000;
            br_done   <= 1'b0;
            br_taken  <= 1'b0;
            taken_cnt <= 16'd0;
        end else begin
            flags_q   <= flags_d;
            br_done   <= br_valid;
            br_taken  <= taken_d;
            taken_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed and randomized checks of flag_branch_unit
// against a behavioural model of the architectural flags and branch rules.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        set_flags;
    logic        alu_zero, alu_neg, alu_ovf, alu_carry;
    logic        reg_zero;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [3:0]  br_cond;
    logic [3:0]  flags_q;
    logic        br_done;
    logic        br_taken;
    logic [15:0] taken_cnt;

    int nvec = 0;
    int nerr = 0;

    // Model state
    logic [3:0]  m_flags;
    logic        m_done;
    logic        m_taken;
    logic [15:0] m_cnt;

    flag_branch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .set_flags (set_flags),
        .alu_zero  (alu_zero),
        .alu_neg   (alu_neg),
        .alu_ovf   (alu_ovf),
        .alu_carry (alu_carry),
        .reg_zero  (reg_zero),
        .br_valid  (br_valid),
        .br_type   (br_type),
        .br_cond   (br_cond),
        .flags_q   (flags_q),
        .br_done   (br_done),
        .br_taken  (br_taken),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ARM condition codes: even codes test a base predicate, odd codes invert it;
    // 14 and 15 always pass.
    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cond[0] && cond != 4'd15) r = !r;
        return r;
    endfunction

    // Advance one clock, update the model, optionally compare all outputs.
    task automatic tick(input bit do_chk);
        logic [3:0] eff;
        logic       tk;
        eff = set_flags ? {alu_neg, alu_zero, alu_carry, alu_ovf} : m_flags;
        tk = 1'b0;
        if (br_valid) begin
            case (br_type)
                2'b00: tk = 1'b1;
                2'b01: tk = reg_zero;
                2'b10: tk = !reg_zero;
                default: tk = ref_cond(br_cond, eff);
            endcase
        end
        @(posedge clk);
        if (reset) begin
            m_flags = 4'b0; m_done = 1'b0; m_taken = 1'b0; m_cnt = 16'd0;
        end else begin
            if (set_flags) m_flags = {alu_neg, alu_zero, alu_carry, alu_ovf};
            m_done  = br_valid;
            m_taken = tk;
            if (tk && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        #1;
        if (do_chk) begin
            check("flags_q",   {28'd0, flags_q},   {28'd0, m_flags});
            check("br_done",   {31'd0, br_done},   {31'd0, m_done});
            check("br_taken",  {31'd0, br_taken},  {31'd0, m_taken});
            check("taken_cnt", {16'd0, taken_cnt}, {16'd0, m_cnt});
        end
    endtask

    task automatic idle();
        set_flags = 0; br_valid = 0;
        alu_zero = 0; alu_neg = 0; alu_ovf = 0; alu_carry = 0;
        reg_zero = 0; br_type = 2'b00; br_cond = 4'd0;
    endtask

    task automatic load_flags(input logic [3:0] nzcv);
        idle();
        set_flags = 1;
        {alu_neg, alu_zero, alu_carry, alu_ovf} = nzcv;
    endtask

    initial begin
        m_flags = 0; m_done = 0; m_taken = 0; m_cnt = 0;
        idle();

        // Reset held together with a branch and a flag write: both discarded.
        reset = 1;
        tick(0);
        load_flags(4'b1111);
        br_valid = 1; br_type = 2'b00;
        tick(1);
        check("rst_flags", {28'd0, flags_q}, 32'd0);
        check("rst_cnt",   {16'd0, taken_cnt}, 32'd0);
        reset = 0;
        idle();
        tick(1);
        check("no_done_after_rst", {31'd0, br_done}, 32'd0);

        // Flag write, then B.cond EQ next cycle uses the updated register.
        load_flags(4'b0100);
        tick(1);
        check("eq_flags", {28'd0, flags_q}, 32'h4);
        idle();
        br_valid = 1; br_type = 2'b11; br_cond = 4'd0;
        tick(1);
        check("eq_taken", {31'd0, br_taken}, 32'd1);
        check("eq_cnt",   {16'd0, taken_cnt}, 32'd1);

        // Same-cycle forwarding: stale flags say LT false, forwarded say true.
        load_flags(4'b0000);
        tick(1);
        load_flags(4'b1000);
        br_valid = 1; br_type = 2'b11; br_cond = 4'd11;
        tick(1);
        check("lt_fwd", {31'd0, br_taken}, 32'd1);

        // CBZ then CBNZ back-to-back with reg_zero = 0; flags untouched.
        idle();
        br_valid = 1; br_type = 2'b01; reg_zero = 0;
        tick(1);
        check("cbz_done",  {31'd0, br_done},  32'd1);
        check("cbz_taken", {31'd0, br_taken}, 32'd0);
        br_type = 2'b10;
        tick(1);
        check("cbnz_done",  {31'd0, br_done},  32'd1);
        check("cbnz_taken", {31'd0, br_taken}, 32'd1);
        check("cb_flags",   {28'd0, flags_q},  32'h8);
        idle();
        tick(1);

        // Full condition sweep against every flag combination.
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            tick(1);
            for (int c = 0; c < 16; c++) begin
                idle();
                br_valid = 1; br_type = 2'b11; br_cond = 4'(c);
                tick(1);
            end
        end

        // Random traffic; unqualified inputs are randomized too.
        idle();
        for (int i = 0; i < 3000; i++) begin
            set_flags = 1'($urandom_range(0, 2) == 0);
            {alu_neg, alu_zero, alu_carry, alu_ovf} = 4'($urandom);
            reg_zero  = 1'($urandom);
            br_valid  = 1'($urandom_range(0, 3) != 0);
            br_type   = 2'($urandom);
            br_cond   = 4'($urandom);
            reset     = 1'($urandom_range(0, 199) == 0);
            tick(1);
        end
        reset = 0;

        // Counter saturation.
        idle();
        reset = 1;
        tick(1);
        reset = 0;
        br_valid = 1; br_type = 2'b00;
        for (int i = 0; i < 65534; i++) tick(0);
        check("cnt_fffe", {16'd0, taken_cnt}, 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("cnt_sat", {16'd0, taken_cnt}, 32'hFFFF);
        end
        idle();
        tick(1);
        check("cnt_hold", {16'd0, taken_cnt}, 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
